// File: rtl/sp_lane_mem_seq.sv
// sp_lane_mem_seq: serialises one N-lane load/store request onto a single
// shared memory port in ascending lane order, returns per-lane load data and
// pulses mready when the whole request is finished.
// Optional feature macro: LANE_COALESCE_EN -- on loads, a lane whose address
// matches the previously serviced lane reuses that data without a memory access.
module sp_lane_mem_seq #(
    parameter int N_LANES = 8,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mread,
    input  logic                        mwrite,
    input  logic [N_LANES-1:0]          en,
    input  logic [N_LANES*ADDR_W-1:0]   addr_in,
    input  logic [N_LANES*DATA_W-1:0]   wdata_in,
    output logic [N_LANES*DATA_W-1:0]   rdata_out,
    output logic                        mready,
    output logic                        busy,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_ack
);

    localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

`ifdef LANE_COALESCE_EN
    localparam logic COALESCE_EN = 1'b1;
`else
    localparam logic COALESCE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                       state_r, state_s;
    logic [N_LANES-1:0]           pend_r, pend_s;
    logic [N_LANES*ADDR_W-1:0]    addr_r, addr_s;
    logic [N_LANES*DATA_W-1:0]    wdata_r, wdata_s;
    logic                         we_r, we_s;
    logic [IDX_W-1:0]             cur_r, cur_s;
    logic                         has_prev_r, has_prev_s;
    logic [ADDR_W-1:0]            prev_addr_r, prev_addr_s;
    logic [DATA_W-1:0]            prev_data_r, prev_data_s;
    logic                         coal_r, coal_s;
    logic [N_LANES*DATA_W-1:0]    rdata_r, rdata_s;
    logic                         mready_r, mready_s;
    logic                         busy_r, busy_s;
    logic                         mem_req_r, mem_req_s;
    logic                         mem_we_r, mem_we_s;
    logic [ADDR_W-1:0]            mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]            mem_wdata_r, mem_wdata_s;
    logic                         advance_s;
    logic [IDX_W-1:0]             sel_s;
    logic [ADDR_W-1:0]            sel_addr_s;

    // Lowest-index set bit of a lane mask (0 when the mask is empty).
    function automatic logic [IDX_W-1:0] first_lane(input logic [N_LANES-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_s     = state_r;
        pend_s      = pend_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        we_s        = we_r;
        cur_s       = cur_r;
        has_prev_s  = has_prev_r;
        prev_addr_s = prev_addr_r;
        prev_data_s = prev_data_r;
        coal_s      = coal_r;
        rdata_s     = rdata_r;
        mready_s    = 1'b0;
        busy_s      = busy_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        advance_s   = 1'b0;
        sel_s       = '0;
        sel_addr_s  = '0;

        case (state_r)
            IDLE: begin
                if (mread || mwrite) begin
                    pend_s     = en;
                    addr_s     = addr_in;
                    wdata_s    = wdata_in;
                    we_s       = mwrite;
                    has_prev_s = 1'b0;
                    busy_s     = 1'b1;
                    advance_s  = 1'b1;
                end else begin
                    mem_req_s  = 1'b0;
                end
            end
            ISSUE: begin
                if (coal_r) begin
                    // Coalesced lane: reuse the data of the previously serviced lane.
                    rdata_s[cur_r*DATA_W +: DATA_W] = prev_data_r;
                    pend_s[cur_r] = 1'b0;
                    advance_s     = 1'b1;
                end else if (mem_ack) begin
                    if (!we_r) begin
                        rdata_s[cur_r*DATA_W +: DATA_W] = mem_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    prev_data_s   = mem_rdata;
                    prev_addr_s   = mem_addr_r;
                    has_prev_s    = 1'b1;
                    pend_s[cur_r] = 1'b0;
                    advance_s     = 1'b1;
                end else begin
                    // Wait state: request outputs keep their registered values.
                    advance_s = 1'b0;
                end
            end
            DONE: begin
                state_s   = IDLE;
                busy_s    = 1'b0;
                mem_req_s = 1'b0;
            end
            default: begin
                state_s   = IDLE;
                busy_s    = 1'b0;
                mem_req_s = 1'b0;
            end
        endcase

        // Pick the next pending lane (or finish) whenever the current step completes.
        if (advance_s) begin
            coal_s    = 1'b0;
            mem_req_s = 1'b0;
            if (pend_s == '0) begin
                state_s  = DONE;
                mready_s = 1'b1;
            end else begin
                sel_s      = first_lane(pend_s);
                sel_addr_s = addr_s[sel_s*ADDR_W +: ADDR_W];
                cur_s      = sel_s;
                state_s    = ISSUE;
                if (COALESCE_EN && !we_s && has_prev_s && (sel_addr_s == prev_addr_s)) begin
                    coal_s = 1'b1;
                end else begin
                    mem_req_s   = 1'b1;
                    mem_we_s    = we_s;
                    mem_addr_s  = sel_addr_s;
                    mem_wdata_s = wdata_s[sel_s*DATA_W +: DATA_W];
                end
            end
        end else begin
            coal_s = coal_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_r      <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            we_r        <= 1'b0;
            cur_r       <= '0;
            has_prev_r  <= 1'b0;
            prev_addr_r <= '0;
            prev_data_r <= '0;
            coal_r      <= 1'b0;
            rdata_r     <= '0;
            mready_r    <= 1'b0;
            busy_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            pend_r      <= pend_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            we_r        <= we_s;
            cur_r       <= cur_s;
            has_prev_r  <= has_prev_s;
            prev_addr_r <= prev_addr_s;
            prev_data_r <= prev_data_s;
            coal_r      <= coal_s;
            rdata_r     <= rdata_s;
            mready_r    <= mready_s;
            busy_r      <= busy_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign rdata_out = rdata_r;
    assign mready    = mready_r;
    assign busy      = busy_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: doc/sp_lane_mem_seq.md
# sp_lane_mem_seq

Parametrised memory sequencer for the SP core array: accepts one load or store request spanning all N lanes of an SM, serialises the enabled lanes' accesses onto a single shared memory port in ascending lane order, returns per-lane load data, and signals completion to the SM controller with a one-cycle `mready` pulse. It sits between the lane array's per-lane `addr`/`data`/`q` buses and the SM's data memory, and gives the array's `MRead`/`MWrite`/`MReady` handshake its behaviour.

## Interface
- `N_LANES`, 8, number of SP lanes (1..32)
- `ADDR_W`, 16, memory address width
- `DATA_W`, 16, memory data width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `mread`  in  1  start load request (sampled in IDLE only)
- `mwrite`  in  1  start store request (sampled in IDLE only; wins if both high)
- `en`  in  N_LANES  lane enable mask, captured at start
- `addr_in`  in  N_LANES*ADDR_W  lane i address at bits [i*ADDR_W +: ADDR_W]
- `wdata_in`  in  N_LANES*DATA_W  lane i store data, same packing
- `rdata_out`  out  N_LANES*DATA_W  registered per-lane load result
- `mready`  out  1  one-cycle completion pulse
- `busy`  out  1  request in progress
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  1 = store, 0 = load
- `mem_addr`  out  ADDR_W  access address
- `mem_wdata`  out  DATA_W  store data
- `mem_rdata`  in  DATA_W  load data, valid with `mem_ack`
- `mem_ack`  in  1  access complete this cycle

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: on `mread|mwrite`, latch `en`→pending mask, all addresses, all store data, op (`mwrite` priority); go ISSUE. Requests while not IDLE are ignored.
- ISSUE: select lowest-index pending lane; drive `mem_req`=1, `mem_we`=op, `mem_addr`/`mem_wdata` from that lane's latched values. On `mem_ack`: for loads write `mem_rdata` into that lane's `rdata_out`; clear its pending bit. When pending becomes empty go DONE, else next lane issued next cycle (`mem_req` may remain high back-to-back).
- Empty mask at start: go straight to DONE, no memory access.
- DONE: `mready`=1 for one cycle, return IDLE.
- `rdata_out` of disabled lanes, and all lanes on stores, unchanged.
- Request outputs held stable while `mem_req`=1 and `mem_ack`=0.

## Timing
- Reset (async assert, sync release): state IDLE, `mready`=0, `busy`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rdata_out`=0, pending=0.
- Reset mid-operation: access abandoned, `mem_req` drops immediately, no `mready`.
- Start sampled at edge t0; `busy`=1 from t0+1 through DONE cycle inclusive.
- Zero-wait memory (`mem_ack` tied 1), k enabled lanes: accesses at t0+1..t0+k, `mready` at t0+k+1. k=0: `mready` at t0+1.
- Each wait cycle (`mem_ack`=0) adds one cycle.
- `mready` and `busy` are registered; next start accepted at cycle after DONE.

## Configuration
- `LANE_COALESCE_EN` defined: on loads, a lane whose address equals the address of the previously serviced lane in the same request copies that lane's data without a memory access (`mem_req`=0 that cycle, one cycle per coalesced lane). Stores never coalesce.
- Undefined: every enabled lane performs its own memory access.

## Test plan
- Load, en=8'hFF, addr lane i = 16'h0010+i, memory returns addr+16'h1000, ack tied 1 -> 8 accesses in order lanes 0..7, `rdata_out` lane i = 16'h1010+i, `mready` at t0+9.
- Store, en=8'b1010_0001, ack delayed 2 cycles each -> accesses to lanes 0,5,7 only, request held stable while waiting, `mready` at t0+10.
- en=0 with `mread` -> no `mem_req`, `mready` at t0+1; `mread` and `mwrite` together -> store performed.
- `mread` pulsed again while busy -> ignored; disabled lanes retain prior `rdata_out`.
- Assert `reset` during third access -> `mem_req`=0 immediately, all outputs at reset values, no `mready`.
- With `LANE_COALESCE_EN`, load en=8'hFF all lanes addr 16'h0040 -> one memory access, all lanes same data, `mready` at t0+9; without it -> 8 accesses.
